// File: rtl/mem_stage_pkg.sv
// rv32i_types: shared types for the memory-access pipeline stage.
//   mem_state_t      - mem_stage FSM states (IDLE, REQ)
//   load_funct3_t    - funct3 encodings of the RV32I load instructions
//   store_funct3_t   - funct3 encodings of the RV32I store instructions
//   regfilemux_sel_t - write-back mux select, carried through this stage
package rv32i_types;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [3:0] {
    rfm_alu_out  = 4'd0,
    rfm_br_en    = 4'd1,
    rfm_u_imm    = 4'd2,
    rfm_load     = 4'd3,
    rfm_pc_plus4 = 4'd4
  } regfilemux_sel_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory port of the memory-access stage.
//   master (the stage): dmem_address, dmem_read, dmem_write, dmem_wdata,
//                       dmem_mbe out; dmem_rdata, dmem_resp in
//   slave  (memory):    the mirror image
// dmem_resp is a single-cycle pulse that completes the outstanding request.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   dmem_address;
  logic                dmem_read;
  logic                dmem_write;
  logic [ADDR_W-1:0]   dmem_wdata;
  logic [ADDR_W/8-1:0] dmem_mbe;
  logic [ADDR_W-1:0]   dmem_rdata;
  logic                dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_mbe,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_mbe,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_store_align.sv
// mem_store_align: combinational byte-lane steering for stores.
//   funct3 - store width code (sb/sh/sw; anything else gives no enables)
//   offset - low two bits of the effective address
//   rs2    - store data as it comes from the register file
//   mbe    - byte enables for the word-aligned access
//   wdata  - store data shifted into its byte lanes
module mem_store_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2,
  output logic [3:0]  mbe,
  output logic [31:0] wdata
);

  always_comb begin
    mbe   = 4'b0000;
    wdata = rs2;
    case (store_funct3_t'(funct3))
      sb: begin
        mbe   = 4'b0001 << offset;
        wdata = rs2 << {offset, 3'b000};
      end
      sh: begin
        // Halfword lane is chosen by offset[1] only; a misaligned
        // offset[0] is silently dropped.
        mbe   = 4'b0011 << {offset[1], 1'b0};
        wdata = rs2 << {offset[1], 4'b0000};
      end
      sw: begin
        mbe   = 4'b1111;
        wdata = rs2;
      end
      default: begin
        // Unknown width: the write strobe still goes out, but no lane
        // is enabled so memory is untouched.
        mbe   = 4'b0000;
        wdata = rs2;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - execute bundle handshake (ready only in IDLE)
//   in_*                - execute bundle: load/store flags, funct3, ALU
//                         result / effective address, store data and the
//                         write-back pass-through fields
//   dmem                - data-memory port (mem_stage_if.master)
//   wb_valid            - one-cycle pulse per completed bundle
//   wb_*                - registered MEM/WB bundle; hold value when idle
// Non-memory bundles reach write-back one cycle after acceptance. Memory
// bundles hold a request on dmem until dmem_resp, then complete.
module mem_stage
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_alu_out,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_br_en,
  input  logic [ADDR_W-1:0] in_u_imm,
  input  logic [ADDR_W-1:0] in_pc,
  input  regfilemux_sel_t   in_regfilemux_sel,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_load_regfile,

  mem_stage_if.master       dmem,

  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_data_value,
  output logic [1:0]        wb_mem_address_last_two_bits,
  output logic [2:0]        wb_funct3,
  output logic [ADDR_W-1:0] wb_alu_out,
  output logic              wb_br_en,
  output logic [ADDR_W-1:0] wb_u_imm,
  output logic [ADDR_W-1:0] wb_pc,
  output regfilemux_sel_t   wb_regfilemux_sel,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_load_regfile
);

  // Fields that travel untouched from execute to write-back.
  typedef struct packed {
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] alu_out;
    logic              br_en;
    logic [ADDR_W-1:0] u_imm;
    logic [ADDR_W-1:0] pc;
    regfilemux_sel_t   regfilemux_sel;
    logic [RD_W-1:0]   rd;
    logic              load_regfile;
  } pass_t;

  mem_state_t        state_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic              req_read_reg;
  logic              req_write_reg;
  logic [ADDR_W-1:0] req_wdata_reg;
  logic [3:0]        req_mbe_reg;
  pass_t             pend_reg;     // bundle parked while the request is out
  pass_t             wb_pass_reg;
  logic [ADDR_W-1:0] wb_data_reg;
  logic              wb_valid_reg;

  pass_t             in_pass;
  logic [3:0]        align_mbe;
  logic [31:0]       align_wdata;
  logic              in_is_mem;

  assign in_pass = '{
    funct3:         in_funct3,
    alu_out:        in_alu_out,
    br_en:          in_br_en,
    u_imm:          in_u_imm,
    pc:             in_pc,
    regfilemux_sel: in_regfilemux_sel,
    rd:             in_rd,
    load_regfile:   in_load_regfile
  };

  assign in_is_mem = in_load | in_store;

  mem_store_align u_store_align (
    .funct3 (in_funct3),
    .offset (in_alu_out[1:0]),
    .rs2    (in_rs2[31:0]),
    .mbe    (align_mbe),
    .wdata  (align_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      req_addr_reg  <= '0;
      req_read_reg  <= 1'b0;
      req_write_reg <= 1'b0;
      req_wdata_reg <= '0;
      req_mbe_reg   <= '0;
      pend_reg      <= '0;
      wb_pass_reg   <= '0;
      wb_data_reg   <= '0;
      wb_valid_reg  <= 1'b0;
    end else begin
      wb_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (in_is_mem) begin
              // A bundle flagged as both load and store is a store.
              state_reg     <= REQ;
              req_addr_reg  <= {in_alu_out[ADDR_W-1:2], 2'b00};
              req_read_reg  <= ~in_store;
              req_write_reg <= in_store;
              req_mbe_reg   <= in_store ? align_mbe : 4'b1111;
              req_wdata_reg <= in_store ? ADDR_W'(align_wdata) : '0;
              pend_reg      <= in_pass;
            end else begin
              wb_pass_reg  <= in_pass;
              wb_data_reg  <= '0;
              wb_valid_reg <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dmem.dmem_resp) begin
            state_reg     <= IDLE;
            req_read_reg  <= 1'b0;
            req_write_reg <= 1'b0;
            wb_data_reg   <= req_write_reg ? '0 : dmem.dmem_rdata;
            wb_pass_reg   <= pend_reg;
            wb_valid_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_reg == IDLE);

  assign dmem.dmem_address = req_addr_reg;
  assign dmem.dmem_read    = req_read_reg;
  assign dmem.dmem_write   = req_write_reg;
  assign dmem.dmem_wdata   = req_wdata_reg;
  assign dmem.dmem_mbe     = req_mbe_reg;

  assign wb_valid                     = wb_valid_reg;
  assign wb_data_value                = wb_data_reg;
  assign wb_mem_address_last_two_bits = wb_pass_reg.alu_out[1:0];
  assign wb_funct3                    = wb_pass_reg.funct3;
  assign wb_alu_out                   = wb_pass_reg.alu_out;
  assign wb_br_en                     = wb_pass_reg.br_en;
  assign wb_u_imm                     = wb_pass_reg.u_imm;
  assign wb_pc                        = wb_pass_reg.pc;
  assign wb_regfilemux_sel            = wb_pass_reg.regfilemux_sel;
  assign wb_rd                        = wb_pass_reg.rd;
  assign wb_load_regfile              = wb_pass_reg.load_regfile;

endmodule
